// File: rtl/rgb_led_sequencer_pkg.sv
// Shared mode encodings, colour constants and colour-step helpers for the LED sequencer.
package led_seq_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 3'd0,
        MODE_SOLID   = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_CYCLE   = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    localparam logic [2:0] COLOUR_RST = 3'b001;
    localparam logic [2:0] COLOUR_MAX = 3'b111;

    // Advance the mode ring; unused codes behave as OFF, so they step to SOLID.
    function automatic mode_e mode_next(input mode_e m);
        case (m)
            MODE_SOLID:   return MODE_BLINK;
            MODE_BLINK:   return MODE_CYCLE;
            MODE_CYCLE:   return MODE_BREATHE;
            MODE_BREATHE: return MODE_OFF;
            default:      return MODE_SOLID;
        endcase
    endfunction

    // Colour walks 1..7 and never lands on 0 (0 would mean all channels dark).
    function automatic logic [2:0] colour_inc(input logic [2:0] c);
        return (c == COLOUR_MAX) ? 3'd1 : c + 3'd1;
    endfunction

    function automatic logic [2:0] colour_dec(input logic [2:0] c);
        return (c <= 3'd1) ? COLOUR_MAX : c - 3'd1;
    endfunction

endpackage

// File: rtl/rgb_led_sequencer_if.sv
// Board-side pins of the sequencer: raw active-low buttons in, active-low LEDs and mode out.
interface rgb_led_sequencer_if;
    import led_seq_pkg::*;

    logic              btn1;
    logic              btn2;
    logic              ledR;
    logic              ledG;
    logic              ledB;
    logic [MODE_W-1:0] mode;

    modport master (output btn1, btn2, input ledR, ledG, ledB, mode);
    modport slave  (input btn1, btn2, output ledR, ledG, ledB, mode);
endinterface

// File: rtl/rgb_led_sequencer_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, one-cycle press pulse on accepted 1->0.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    // Synchronise the raw pin; resets to released so a held button still yields a press later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from the current one for the full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl     <= 1'b1;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            pressed <= 1'b0;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                lvl     <= s2;
                cnt     <= '0;
                pressed <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED pattern controller: debounced buttons, mode FSM, step/ramp prescalers, per-channel PWM.
module rgb_led_sequencer
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int STEP_CYCLES     = 5400000,
    parameter int RAMP_CYCLES     = 105000,
    parameter int PWM_BITS        = 8,
    parameter int BRIGHT          = 64
) (
    input  logic                clk,
    input  logic                rst,
    rgb_led_sequencer_if.slave  bus
);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int RW = $clog2(RAMP_CYCLES + 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_D = PWM_BITS'(BRIGHT);

    logic                     p1, p2;
    mode_e                    mode_q, mode_d;
    logic [2:0]               colour;
    logic                     dir;      // 0 = up, 1 = down
    logic                     phase;    // 1 = on
    logic [PWM_BITS-1:0]      level;
    logic [SW-1:0]            step_cnt;
    logic [RW-1:0]            ramp_cnt;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [2:0][PWM_BITS-1:0] duty;
    logic [2:0]               lit;
    logic [2:0]               led_q;
    logic                     step_tick, ramp_tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk(clk), .rst(rst), .btn_n(bus.btn1), .pressed(p1));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk(clk), .rst(rst), .btn_n(bus.btn2), .pressed(p2));

    assign step_tick = (step_cnt == SW'(STEP_CYCLES - 1));
    assign ramp_tick = (mode_q == MODE_BREATHE) && (ramp_cnt == RW'(RAMP_CYCLES - 1));

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= MODE_OFF;
        else     mode_q <= mode_d;
    end

    // Next mode: btn1 press walks the ring.
    always_comb begin
        mode_d = mode_q;
        if (p1) mode_d = mode_next(mode_q);
    end

    // Pattern state; a mode change restarts everything and swallows a coincident btn2 press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour   <= COLOUR_RST;
            dir      <= 1'b0;
            phase    <= 1'b1;
            level    <= '0;
            step_cnt <= '0;
            ramp_cnt <= '0;
        end else if (p1) begin
            dir      <= 1'b0;
            phase    <= 1'b1;
            level    <= '0;
            step_cnt <= '0;
            ramp_cnt <= '0;
        end else begin
            step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
            ramp_cnt <= (mode_q != MODE_BREATHE || ramp_tick) ? '0 : ramp_cnt + 1'b1;
            if (mode_q == MODE_BLINK && step_tick) phase <= ~phase;
            if (mode_q == MODE_CYCLE && step_tick)
                colour <= dir ? colour_dec(colour) : colour_inc(colour);
            else if (p2 && (mode_q == MODE_SOLID || mode_q == MODE_BLINK || mode_q == MODE_BREATHE))
                colour <= colour_inc(colour);
            if (p2 && mode_q == MODE_CYCLE) begin
                dir <= ~dir;
            end else if (ramp_tick) begin
                // Triangle: turn around on reaching an endpoint so each endpoint lasts one ramp step.
                if (!dir) begin
                    level <= level + 1'b1;
                    if (level == BRIGHT_D - 1'b1) dir <= 1'b1;
                end else begin
                    level <= level - 1'b1;
                    if (level == {{(PWM_BITS-1){1'b0}}, 1'b1}) dir <= 1'b0;
                end
            end
        end
    end

    // Per-channel duty from mode, colour bit, blink phase and breathe level.
    always_comb begin
        duty = '0;
        lit  = '0;
        for (int i = 0; i < 3; i++) begin
            case (mode_q)
                MODE_SOLID, MODE_CYCLE: duty[i] = colour[i] ? BRIGHT_D : '0;
                MODE_BLINK:             duty[i] = (colour[i] && phase) ? BRIGHT_D : '0;
                MODE_BREATHE:           duty[i] = colour[i] ? level : '0;
                default:                duty[i] = '0;
            endcase
            lit[i] = (duty[i] > pwm_cnt);
        end
    end

    // Free-running PWM counter and registered active-low LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            led_q   <= 3'b111;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_q   <= ~lit;
        end
    end

    assign bus.ledR = led_q[0];
    assign bus.ledG = led_q[1];
    assign bus.ledB = led_q[2];
    assign bus.mode = mode_q;
endmodule
